dmem_burst_arbiter: RTL and testbench
=====================================

Name: dmem_burst_arbiter

Overview:
Round-robin burst arbiter that shares the single-port 64-bit data memory (16-bit word address, 49152 words, 1-cycle registered read, write-through on write) between NUM_REQ requesters, e.g. the vector load/store unit and the image loader. Each grant is one burst of consecutive words. The block generates the per-beat addresses, the write strobes and the per-requester beat and read-valid handshakes. It sits directly between the requesters and the memory port.

Parameters:
NUM_REQ, 2, number of requesters
ADDR_W, 16, memory word-address width
DATA_W, 64, memory word width
LEN_W, 8, burst length field width (beats)
MEM_DEPTH, 49152, valid words; addresses >= MEM_DEPTH are illegal

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reqValid  in  NUM_REQ  request pending, per requester
reqWrite  in  NUM_REQ  1 = write burst, 0 = read burst
reqAddr  in  NUM_REQ*ADDR_W  burst base address (requester i in slice i)
reqLen  in  NUM_REQ*LEN_W  beat count; 0 is illegal
reqWData  in  NUM_REQ*DATA_W  current write beat data
beatAck  out  NUM_REQ  beat issued this cycle; requester presents next wdata after this edge
rdValid  out  NUM_REQ  rdData holds a read beat for requester i
rdData  out  DATA_W  memOut passthrough
done  out  NUM_REQ  1-cycle pulse, burst complete
err  out  NUM_REQ  1-cycle pulse, burst rejected
busy  out  1  state != IDLE
memAddress  out  ADDR_W  to memory address
memInputData  out  DATA_W  to memory inputData
memWriteEnable  out  1  to memory writeEnable
memOut  in  DATA_W  from memory out

Behaviour:
- FSM states: IDLE, BURST, FINISH, ERROR. Reset -> IDLE. Reset values: rrPtr so requester 0 has top priority; all per-requester outputs 0; memWriteEnable 0; memAddress 0.
- Arbitration in IDLE:
  - Select the first asserted reqValid starting at rrPtr+1 (mod NUM_REQ).
  - Capture g, reqWrite[g], curAddr=reqAddr[g] and remaining=reqLen[g].
  - Legality check: len==0, or reqAddr+reqLen > MEM_DEPTH, computed at ADDR_W+1 bits (no wrap). Illegal -> ERROR; legal -> BURST.
- BURST (one beat per cycle):
  - Drive memAddress=curAddr, memWriteEnable=write, memInputData=reqWData[g], beatAck[g]=1.
  - Edge: curAddr++, remaining--.
  - Last beat (remaining==1) -> FINISH.
- Read data: the beat issued in cycle k returns in cycle k+1 as rdValid[g]=1 with rdData=memOut. rdValid is never asserted for writes.
- FINISH: done[g]=1 (coincides with the final rdValid for reads). rrPtr<=g. Next state IDLE.
- ERROR: err[g]=1, no memory access, rrPtr<=g, next state IDLE.
- Timing for a burst of L beats accepted in IDLE at cycle 0:
  - Beats in cycles 1..L.
  - done in cycle L+1.
  - IDLE again in cycle L+2; the next grant is evaluated in that cycle.
- Outside BURST: memWriteEnable=0, beatAck=0, memAddress holds its last value.
- The requester holds reqValid/reqWrite/reqAddr/reqLen stable until done or err. Deasserting reqValid mid-burst is ignored; the burst completes.
- Reset mid-burst:
  - memWriteEnable and beatAck are gated to 0 combinationally while reset=1, so no corrupting write occurs.
  - The FSM returns to IDLE at the edge, and the burst is abandoned without done.
  - Any rdValid due in the following cycle is suppressed.
- Simultaneous requests: only one grant per IDLE cycle. A requester not granted keeps waiting. Starvation bound: NUM_REQ-1 bursts.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, BURST, FINISH, ERROR), ADDR_W/DATA_W/LEN_W/MEM_DEPTH constants.
- Sub-module rr_select (NUM_REQ): combinational round-robin pick from reqValid and rrPtr, outputs grant index and anyValid.
- Address/length counters and the FSM stay in the top module.

Test Plan:
- Single read, req0 addr 0x0010 len 4, memory preloaded word i = i:
  - beatAck[0] in cycles 1-4 with memAddress 0x10..0x13.
  - rdValid[0] in cycles 2-5 with rdData 0x10..0x13.
  - done[0] in cycle 5.
- Write burst, req1 addr 0x0100 len 3, wdata advanced on each beatAck (0xA, 0xB, 0xC):
  - memWriteEnable=1 for exactly 3 cycles.
  - A subsequent read of 0x100..0x102 returns A, B, C.
- Both requesters asserted continuously, len 2 each: grants alternate 0,1,0,1 after reset; each burst spans 4 cycles.
- Illegal requests:
  - addr 0xBFFF len 2: err pulse 1 cycle after selection, memWriteEnable never asserted.
  - len 0: err pulse.
  - addr 0xBFFE len 2 (last two words): accepted, done.
- Reset asserted in beat 2 of a 4-beat write: memWriteEnable=0 during reset, only beat 1 written, no done, next request served normally.
- reqValid dropped after beat 1 of a 3-beat read: all 3 rdValid pulses and done still produced.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory burst arbiter.
// Memory geometry: 64-bit words, 16-bit word address, 49152 valid words.
package dmem_arb_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 64;
  localparam int LEN_W     = 8;
  localparam int MEM_DEPTH = 49152;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FINISH,
    ERROR
  } state_e;

  // Width of a requester index; stays at least 1 bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_burst_arbiter_if.sv
// Requester and memory-port signals of the burst arbiter.
// The slave side is the arbiter; the master side is the requesters plus memory.
interface dmem_burst_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import dmem_arb_pkg::*;

  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ-1:0]        reqWrite;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ*LEN_W-1:0]  reqLen;
  logic [NUM_REQ*DATA_W-1:0] reqWData;
  logic [NUM_REQ-1:0]        beatAck;
  logic [NUM_REQ-1:0]        rdValid;
  logic [DATA_W-1:0]         rdData;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      busy;
  logic [ADDR_W-1:0]         memAddress;
  logic [DATA_W-1:0]         memInputData;
  logic                      memWriteEnable;
  logic [DATA_W-1:0]         memOut;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqLen, reqWData, memOut,
    output beatAck, rdValid, rdData, done, err, busy,
           memAddress, memInputData, memWriteEnable
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqLen, reqWData, memOut,
    input  beatAck, rdValid, rdData, done, err, busy,
           memAddress, memInputData, memWriteEnable
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request after rr_ptr_i,
// wrapping modulo NUM_REQ, so the last-served requester has lowest priority.
module rr_select
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant_o     = '0;
    any_valid_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid_o && req_valid_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        any_valid_o = 1'b1;
        grant_o     = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/dmem_burst_arbiter.sv
// Round-robin burst arbiter in front of the single-port data memory: one burst
// of consecutive words per grant, with per-beat ack and read-valid back to the owner.
module dmem_burst_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input logic                 clk,
  input logic                 reset,
  dmem_burst_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]   rd_g_q, rd_g_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               any_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [ADDR_W:0]    sel_end;
  logic               sel_legal;

  logic [NUM_REQ-1:0] beat_ack;
  logic [NUM_REQ-1:0] rd_valid;
  logic [NUM_REQ-1:0] done_pulse;
  logic [NUM_REQ-1:0] err_pulse;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_valid_i (bus.reqValid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (sel_idx),
    .any_valid_o (any_valid)
  );

  // End address is formed one bit wider so a burst running past the top cannot wrap.
  assign sel_addr  = bus.reqAddr[int'(sel_idx)*ADDR_W +: ADDR_W];
  assign sel_len   = bus.reqLen[int'(sel_idx)*LEN_W +: LEN_W];
  assign sel_end   = {1'b0, sel_addr} + (ADDR_W+1)'(sel_len);
  assign sel_legal = (sel_len != '0) && (sel_end <= (ADDR_W+1)'(MEM_DEPTH));

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    write_d     = write_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    rd_pend_d   = 1'b0;
    rd_g_d      = rd_g_q;
    beat_ack    = '0;
    done_pulse  = '0;
    err_pulse   = '0;
    mem_we      = 1'b0;
    mem_addr    = last_addr_q;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          g_d         = sel_idx;
          write_d     = bus.reqWrite[sel_idx];
          cur_addr_d  = sel_addr;
          remaining_d = sel_len;
          state_d     = sel_legal ? BURST : ERROR;
        end
      end
      BURST: begin
        beat_ack[g_q] = 1'b1;
        mem_we        = write_q;
        mem_addr      = cur_addr_q;
        last_addr_d   = cur_addr_q;
        cur_addr_d    = cur_addr_q + ADDR_W'(1);
        remaining_d   = remaining_q - LEN_W'(1);
        rd_pend_d     = !write_q;
        rd_g_d        = g_q;
        if (remaining_q == LEN_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        done_pulse[g_q] = 1'b1;
        rr_ptr_d        = g_q;
        state_d         = IDLE;
      end
      ERROR: begin
        err_pulse[g_q] = 1'b1;
        rr_ptr_d       = g_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      write_q     <= 1'b0;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      remaining_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_g_q      <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      write_q     <= write_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      remaining_q <= remaining_d;
      rd_pend_q   <= rd_pend_d;
      rd_g_q      <= rd_g_d;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (rd_pend_q) rd_valid[rd_g_q] = 1'b1;
  end

  // Reset kills the in-flight beat immediately so the memory never sees a partial write.
  assign bus.beatAck        = reset ? '0 : beat_ack;
  assign bus.memWriteEnable = mem_we & ~reset;
  assign bus.memAddress     = mem_addr;
  assign bus.memInputData   = bus.reqWData[int'(g_q)*DATA_W +: DATA_W];
  assign bus.rdValid        = rd_valid;
  assign bus.rdData         = bus.memOut;
  assign bus.done           = done_pulse;
  assign bus.err            = err_pulse;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_burst_arbiter.sv
// Bench for dmem_burst_arbiter: directed requests push expected beats, read data
// and completions into per-requester queues; a negedge monitor pops and compares.
module tb_dmem_burst_arbiter;
  import dmem_arb_pkg::*;

  localparam int NR = 2;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                wr;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   we_cnt   = 0;

  ev_t               beat_q [NR][$];
  ev_t               rd_q   [NR][$];
  ev_t               fin_q  [NR][$];
  logic [DATA_W-1:0] wq     [NR][$];
  logic [DATA_W-1:0] mem     [int];
  logic [DATA_W-1:0] ref_mem [int];

  dmem_burst_arbiter_if #(.NUM_REQ(NR)) bus ();

  dmem_burst_arbiter #(.NUM_REQ(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : DATA_W'(a);
  endfunction

  // Memory: word i powers up holding i; 1-cycle registered read, write-through.
  initial begin
    int a;
    bus.memOut = '0;
    forever begin
      @(posedge clk);
      a = int'(bus.memAddress);
      if (bus.memWriteEnable) begin
        mem[a] = bus.memInputData;
        bus.memOut <= bus.memInputData;
      end else begin
        bus.memOut <= mem.exists(a) ? mem[a] : DATA_W'(a);
      end
    end
  end

  // Write-data driver: each requester advances to its next word after a beatAck.
  initial begin
    logic [NR-1:0] ack;
    bus.reqWData = '0;
    forever begin
      @(negedge clk);
      ack = bus.beatAck;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (ack[r] && wq[r].size() > 0) void'(wq[r].pop_front());
        bus.reqWData[r*DATA_W +: DATA_W] = (wq[r].size() > 0) ? wq[r][0] : '0;
      end
    end
  end

  // Monitor: every DUT-produced event must match the head of its queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.memWriteEnable) begin
          we_cnt++;
          check("we_has_beat", 64'(|bus.beatAck), 64'd1);
        end
        for (int r = 0; r < NR; r++) begin
          if (bus.beatAck[r]) begin
            if (beat_q[r].size() == 0) check("beat_unexpected", 64'(bus.beatAck[r]), 64'd0);
            else begin
              e = beat_q[r].pop_front();
              check("beat_cyc", 64'(cyc), 64'(e.cyc));
              check("beat_addr", 64'(bus.memAddress), 64'(e.addr));
              check("beat_we", 64'(bus.memWriteEnable), 64'(e.wr));
              if (e.wr) check("beat_wdata", bus.memInputData, e.data);
            end
          end
          if (bus.rdValid[r]) begin
            if (rd_q[r].size() == 0) check("rd_unexpected", 64'(bus.rdValid[r]), 64'd0);
            else begin
              e = rd_q[r].pop_front();
              check("rd_cyc", 64'(cyc), 64'(e.cyc));
              check("rd_data", bus.rdData, e.data);
            end
          end
          if (bus.done[r] || bus.err[r]) begin
            if (fin_q[r].size() == 0) check("fin_unexpected", 64'(bus.done[r] | bus.err[r]), 64'd0);
            else begin
              e = fin_q[r].pop_front();
              check("fin_cyc", 64'(cyc), 64'(e.cyc));
              check("fin_kind_done", 64'(bus.done[r]), 64'(e.data == 1));
              check("fin_kind_err", 64'(bus.err[r]), 64'(e.data == 2));
            end
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_burst(input int r, input bit wr, input logic [ADDR_W-1:0] a,
                            input int len, input int t0);
    ev_t e;
    for (int k = 0; k < len; k++) begin
      int ad;
      ad     = int'(a) + k;
      e.cyc  = t0 + 1 + k;
      e.addr = ADDR_W'(ad);
      e.wr   = wr;
      if (wr) begin
        e.data      = wq[r][k];
        ref_mem[ad] = e.data;
      end else begin
        e.data = ref_rd(ad);
      end
      beat_q[r].push_back(e);
      if (!wr) begin
        e.cyc = t0 + 2 + k;
        rd_q[r].push_back(e);
      end
    end
    e.cyc  = t0 + len + 1;
    e.data = 1;
    fin_q[r].push_back(e);
  endtask

  task automatic push_err(input int r, input int t0);
    ev_t e;
    e.cyc  = t0 + 1;
    e.addr = '0;
    e.data = 2;
    e.wr   = 1'b0;
    fin_q[r].push_back(e);
  endtask

  task automatic req(input int r, input bit wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
    bus.reqValid[r]                  = 1'b1;
    bus.reqWrite[r]                  = wr;
    bus.reqAddr[r*ADDR_W +: ADDR_W]  = a;
    bus.reqLen[r*LEN_W +: LEN_W]     = len;
  endtask

  // Bounded wait for done/err of requester r, then the requester drops its request.
  task automatic wait_fin(input int r);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.done[r] || bus.err[r]) seen = 1'b1;
    end
    check("fin_seen", 64'(seen), 64'd1);
    step();
    bus.reqValid[r] = 1'b0;
  endtask

  initial begin
    int  t0;
    int  we0;
    ev_t e;

    reset        = 1'b1;
    bus.reqValid = '0;
    bus.reqWrite = '0;
    bus.reqAddr  = '0;
    bus.reqLen   = '0;
    step(3);
    reset = 1'b0;

    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_beatAck", 64'(bus.beatAck), 64'd0);
    check("rst_rdValid", 64'(bus.rdValid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_we", 64'(bus.memWriteEnable), 64'd0);
    check("rst_memAddress", 64'(bus.memAddress), 64'd0);
    step();

    // Single 4-beat read from req0.
    t0 = cyc;
    push_burst(0, 1'b0, 16'h0010, 4, t0);
    req(0, 1'b0, 16'h0010, 8'd4);
    @(negedge clk);
    check("idle_before_grant", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("busy_in_burst", 64'(bus.busy), 64'd1);
    wait_fin(0);

    // 3-beat write from req1, then read it back.
    wq[1].push_back(64'hA);
    wq[1].push_back(64'hB);
    wq[1].push_back(64'hC);
    we0 = we_cnt;
    t0  = cyc;
    push_burst(1, 1'b1, 16'h0100, 3, t0);
    req(1, 1'b1, 16'h0100, 8'd3);
    wait_fin(1);
    check("wr_we_cycles", 64'(we_cnt - we0), 64'd3);
    t0 = cyc;
    push_burst(0, 1'b0, 16'h0100, 3, t0);
    req(0, 1'b0, 16'h0100, 8'd3);
    wait_fin(0);

    // Both requesters held busy after a fresh reset: grants 0,1,0,1 every 4 cycles.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    t0 = cyc;
    push_burst(0, 1'b0, 16'h0020, 2, t0);
    push_burst(1, 1'b0, 16'h0030, 2, t0 + 4);
    push_burst(0, 1'b0, 16'h0020, 2, t0 + 8);
    push_burst(1, 1'b0, 16'h0030, 2, t0 + 12);
    req(0, 1'b0, 16'h0020, 8'd2);
    req(1, 1'b0, 16'h0030, 8'd2);
    step(16);
    bus.reqValid = '0;
    step(2);

    // Illegal requests, then the last two legal words.
    we0 = we_cnt;
    t0  = cyc;
    push_err(0, t0);
    req(0, 1'b0, 16'hBFFF, 8'd2);
    wait_fin(0);
    t0 = cyc;
    push_err(1, t0);
    req(1, 1'b1, 16'h0000, 8'd0);
    wait_fin(1);
    check("err_no_write", 64'(we_cnt - we0), 64'd0);
    t0 = cyc;
    push_burst(0, 1'b0, 16'hBFFE, 2, t0);
    req(0, 1'b0, 16'hBFFE, 8'd2);
    wait_fin(0);

    // Reset during beat 2 of a 4-beat write: only beat 1 lands, no done.
    wq[0].push_back(64'hD0);
    wq[0].push_back(64'hD1);
    wq[0].push_back(64'hD2);
    wq[0].push_back(64'hD3);
    t0     = cyc;
    e.cyc  = t0 + 1;
    e.addr = 16'h0200;
    e.data = 64'hD0;
    e.wr   = 1'b1;
    beat_q[0].push_back(e);
    ref_mem[16'h0200] = 64'hD0;
    req(0, 1'b1, 16'h0200, 8'd4);
    step(2);
    reset           = 1'b1;
    bus.reqValid[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_we_gated", 64'(bus.memWriteEnable), 64'd0);
    check("rst_mid_ack_gated", 64'(bus.beatAck), 64'd0);
    step();
    reset = 1'b0;
    wq[0].delete();
    @(negedge clk);
    check("rst_mid_idle", 64'(bus.busy), 64'd0);
    step();
    t0 = cyc;
    push_burst(1, 1'b0, 16'h0200, 2, t0);
    req(1, 1'b0, 16'h0200, 8'd2);
    wait_fin(1);

    // reqValid dropped after beat 1: the burst still completes.
    t0 = cyc;
    push_burst(0, 1'b0, 16'h0040, 3, t0);
    req(0, 1'b0, 16'h0040, 8'd3);
    step(2);
    bus.reqValid[0] = 1'b0;
    wait_fin(0);

    step(3);
    for (int r = 0; r < NR; r++) begin
      check("beat_q_left", 64'(beat_q[r].size()), 64'd0);
      check("rd_q_left", 64'(rd_q[r].size()), 64'd0);
      check("fin_q_left", 64'(fin_q[r].size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
